// File: rtl/parallel_to_serial_tx_if.sv
// Handshake and serial-line bundle for parallel_to_serial_tx.
// master: frame source / line observer; slave: the transmitter.
//   enable     bit-rate qualifier
//   framesize  frame length in bits (sampled on accept)
//   load       start-of-frame request
//   parallel   word to send, bit framesize-1 first
//   ready      transmitter idle, load may be accepted
//   serial     serial data (1 when not shifting)
//   serial_oe  pad output enable for serial
//   busy       frame in progress (SHIFT or DONE)
//   complete   one-cycle end-of-frame pulse
interface parallel_to_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] framesize;
    logic             load;
    logic [WIDTH-1:0] parallel;
    logic             ready;
    logic             serial;
    logic             serial_oe;
    logic             busy;
    logic             complete;

    modport master (
        output enable,
        output framesize,
        output load,
        output parallel,
        input  ready,
        input  serial,
        input  serial_oe,
        input  busy,
        input  complete
    );

    modport slave (
        input  enable,
        input  framesize,
        input  load,
        input  parallel,
        output ready,
        output serial,
        output serial_oe,
        output busy,
        output complete
    );
endinterface

// File: rtl/parallel_to_serial_tx.sv
// Parallel-to-serial transmitter: sends the low framesize bits of a
// word, MSB of the frame first, with a pad output enable per bit.
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  parallel_to_serial_tx_if.slave (handshake + serial line)
module parallel_to_serial_tx #(
    parameter int WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    parallel_to_serial_tx_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] WMAX = WIDTH[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] fsz_r;
    logic [WIDTH-1:0] count;

    logic [WIDTH-1:0] fsz_in;
    logic [WIDTH-1:0] last_idx;
    logic             accept;
    logic             last_bit;
    logic             step;

    // Oversized frames are clamped so the counter can never wrap.
    always_comb begin
        fsz_in = bus.framesize;
        if (bus.framesize > WMAX) begin
            fsz_in = WMAX;
        end
    end

    assign accept   = (state == IDLE) && bus.load && bus.enable;
    assign step     = (state == SHIFT) && bus.enable;
    // Only meaningful in SHIFT, where fsz_r >= 1.
    assign last_idx = fsz_r - ONE;
    assign last_bit = (count == last_idx);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    // An empty frame skips straight to the
                    // completion pulse without driving the line.
                    if (fsz_in == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (step && last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, advance one bit per
    // enabled edge. The final bit leaves shreg untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            fsz_r <= '0;
            count <= '0;
        end else if (accept) begin
            shreg <= bus.parallel;
            fsz_r <= fsz_in;
            count <= '0;
        end else if (step && !last_bit) begin
            count <= count + ONE;
            shreg <= shreg << 1;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        bus.ready     = 1'b0;
        bus.busy      = 1'b0;
        bus.complete  = 1'b0;
        bus.serial_oe = 1'b0;
        bus.serial    = 1'b1;
        unique case (state)
            IDLE: begin
                bus.ready = 1'b1;
            end
            SHIFT: begin
                bus.busy      = 1'b1;
                bus.serial_oe = 1'b1;
                bus.serial    = shreg[last_idx[CW-1:0]];
            end
            DONE: begin
                bus.busy     = 1'b1;
                bus.complete = 1'b1;
            end
            default: begin
                bus.ready = 1'b0;
            end
        endcase
    end

endmodule
